// File: rtl/sram_model_param.sv
// sram_model_param: parametrised cycle-accurate SRAM model with byte lanes,
// per-op latency, busy/done status and abort-on-deassert.
module sram_model_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int WR_LAT = 3,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CE,
  input  logic                  OE,
  input  logic                  WE,
  input  logic [DATA_W/8-1:0]   BE_N,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  busy,
  output logic                  done
);
  localparam int NB = DATA_W / 8;
  localparam int ML = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
  localparam int CW = $clog2(ML + 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic op_q, cur_op, q, start, fin, busy_q, done_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n, lat;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [DATA_W-1:0] din_q, cur_din, dout_q, dout_d, rd_word;
  logic [NB-1:0] be_q, cur_be;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // An op change while in ACCESS restarts the count exactly like an IDLE start.
  always_comb begin
    q = !CE && !OE;
    start = q && (state_q == IDLE || WE != op_q);
    cur_op = start ? WE : op_q;
    cur_addr = start ? addr : addr_q;
    cur_din = start ? din : din_q;
    cur_be = start ? BE_N : be_q;
    cnt_n = start ? CW'(1) : cnt_q + CW'(1);
    lat = cur_op ? CW'(RD_LAT) : CW'(WR_LAT);
    fin = q && cnt_n == lat;
    state_d = q && !fin ? ACCESS : IDLE;
    cnt_d = state_d == ACCESS ? cnt_n : '0;
    rd_word = '0;
    for (int i = 0; i < NB; i++)
      rd_word[8*i+:8] = cur_be[i] ? 8'h00 : mem[cur_addr][8*i+:8];
    dout_d = fin && cur_op ? rd_word : dout_q;
  end
  // The array has no reset branch: contents survive rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dout_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      op_q <= 1'b1;
      addr_q <= '0;
      din_q <= '0;
      be_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= state_d == ACCESS;
      done_q <= fin;
      dout_q <= dout_d;
      if (start) begin
        op_q <= WE;
        addr_q <= addr;
        din_q <= din;
        be_q <= BE_N;
      end
      if (fin && !cur_op)
        for (int i = 0; i < NB; i++)
          if (!cur_be[i]) mem[cur_addr][8*i+:8] <= cur_din[8*i+:8];
    end
  end
  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_sram_model_param.sv
// tb_sram_model_param: directed test-plan scenarios plus randomized traffic
// checked against a transaction-level reference model; second instance sweeps LAT=1.
module tb_sram_model_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ce, oe, we;
  logic [1:0] be;
  logic [9:0] addr;
  logic [15:0] din, dout;
  logic busy, done;
  logic s_ce, s_oe, s_we;
  logic [3:0] s_be, s_addr;
  logic [31:0] s_din, s_dout;
  logic s_busy, s_done;
  int n_vec = 0, n_err = 0;
  string phase = "reset";
  logic [15:0] mm [1024];
  bit m_act = 0, m_op = 1, m_done = 0;
  int m_n = 0;
  logic [9:0] m_addr;
  logic [15:0] m_din, m_dout = 16'h0;
  logic [1:0] m_be;

  sram_model_param dut (
    .clk(clk), .rst(rst), .CE(ce), .OE(oe), .WE(we), .BE_N(be),
    .addr(addr), .din(din), .dout(dout), .busy(busy), .done(done)
  );

  sram_model_param #(.DATA_W(32), .ADDR_W(4), .WR_LAT(1), .RD_LAT(1)) dut_s (
    .clk(clk), .rst(rst), .CE(s_ce), .OE(s_oe), .WE(s_we), .BE_N(s_be),
    .addr(s_addr), .din(s_din), .dout(s_dout), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: an access is a run of consecutive enabled edges with the same WE;
  // it takes effect when the run length reaches that op's latency.
  task automatic model_edge(input bit c, o, w, input logic [1:0] b,
                            input logic [9:0] a, input logic [15:0] d);
    m_done = 0;
    if (c || o) m_act = 0;
    else begin
      if (!m_act || w != m_op) begin
        m_act = 1; m_op = w; m_addr = a; m_din = d; m_be = b; m_n = 0;
      end
      m_n++;
      if (m_n == (m_op ? 2 : 3)) begin
        for (int i = 0; i < 2; i++)
          if (m_op) m_dout[8*i+:8] = m_be[i] ? 8'h00 : mm[m_addr][8*i+:8];
          else if (!m_be[i]) mm[m_addr][8*i+:8] = m_din[8*i+:8];
        m_act = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic tick(input bit c, o, w, input logic [1:0] b,
                      input logic [9:0] a, input logic [15:0] d);
    ce = c; oe = o; we = w; be = b; addr = a; din = d;
    @(posedge clk);
    model_edge(c, o, w, b, a, d);
    #1;
    chk({phase, ".dout"}, dout, m_dout);
    chk({phase, ".busy"}, busy, m_act);
    chk({phase, ".done"}, done, m_done);
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] b);
    repeat (3) tick(0, 0, 0, b, a, d);
  endtask

  task automatic rd(input logic [9:0] a, input logic [1:0] b);
    repeat (2) tick(0, 0, 1, b, a, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit rc, ro, rw;
    logic [9:0] ra;
    rst = 1; ce = 1; oe = 1; we = 1; be = 0; addr = 0; din = 0;
    s_ce = 1; s_oe = 1; s_we = 1; s_be = 0; s_addr = 0; s_din = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.dout", dout, 16'h0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    rst = 0;
    phase = "preinit";
    for (int a = 0; a < 32; a++) wr(10'(a), 16'h0, 2'b00);
    phase = "defaults";
    wr(10'h005, 16'hBEEF, 2'b00);
    rd(10'h005, 2'b00);
    chk("defaults.rd", dout, 16'hBEEF);
    phase = "lanes";
    wr(10'h00A, 16'h1234, 2'b00);
    wr(10'h00A, 16'hABCD, 2'b01);
    rd(10'h00A, 2'b00);
    chk("lanes.full", dout, 16'hAB34);
    rd(10'h00A, 2'b10);
    chk("lanes.low", dout, 16'h0034);
    phase = "abort";
    tick(0, 0, 0, 2'b00, 10'h010, 16'h5555);
    tick(0, 0, 0, 2'b00, 10'h010, 16'h5555);
    tick(0, 1, 0, 2'b00, 10'h010, 16'h5555);
    chk("abort.busy", busy, 0);
    tick(1, 1, 1, 2'b00, 10'h0, 16'h0);
    rd(10'h010, 2'b00);
    chk("abort.rd", dout, 16'h0000);
    phase = "opchg";
    tick(0, 0, 1, 2'b00, 10'h003, 16'h0);
    tick(0, 0, 0, 2'b00, 10'h004, 16'h0F0F);
    tick(0, 0, 0, 2'b00, 10'h007, 16'hFFFF);
    tick(0, 0, 0, 2'b00, 10'h008, 16'h1234);
    chk("opchg.done", done, 1);
    chk("opchg.dout_held", dout, 16'h0000);
    rd(10'h004, 2'b00);
    chk("opchg.rd", dout, 16'h0F0F);
    phase = "rstmid";
    wr(10'h020, 16'h1111, 2'b00);
    tick(0, 0, 0, 2'b00, 10'h020, 16'h7777);
    tick(0, 0, 0, 2'b00, 10'h020, 16'h7777);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rstmid.dout", dout, 16'h0);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    m_act = 0; m_dout = 0; m_done = 0;
    ce = 1; oe = 1;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    rd(10'h020, 2'b00);
    chk("rstmid.rd", dout, 16'h1111);
    phase = "random";
    rw = 1; ra = 0;
    for (int k = 0; k < 500; k++) begin
      rc = $urandom_range(0, 9) == 0;
      ro = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 4) == 0) rw = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) ra = 10'($urandom_range(0, 31));
      tick(rc, ro, rw, 2'($urandom_range(0, 3)), ra, 16'($urandom));
    end
    ce = 1; oe = 1;
    phase = "sweep";
    s_ce = 0; s_oe = 0; s_be = 4'h0;
    for (int a = 0; a < 16; a++) begin
      s_we = 0; s_addr = 4'(a); s_din = 32'(a) * 32'h01010101;
      @(posedge clk); #1;
      chk("sweep.wr_done", s_done, 1);
      s_we = 1; s_din = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      chk("sweep.rd_done", s_done, 1);
      chk("sweep.rd", s_dout, 32'(a) * 32'h01010101);
    end
    s_addr = 4'h0;
    @(posedge clk); #1;
    chk("sweep.noalias0", s_dout, 32'h0);
    s_addr = 4'hF;
    @(posedge clk); #1;
    chk("sweep.top", s_dout, 32'h0F0F0F0F);
    s_ce = 1; s_oe = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
